// File: rtl/if_fetch_bpu.sv
// Fetch-side PC register with a direct-mapped BTB and 2-bit saturating counters.
// EX trains the table on branch resolution and redirects the PC on a mispredict.
module if_fetch_bpu #(
  parameter int unsigned IDX_W    = 6,
  parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        upd_valid,
  input  logic [31:0] upd_pc,
  input  logic        upd_taken,
  input  logic [31:0] upd_target,
  output logic [31:0] pc_if,
  output logic        predict_if,
  output logic        flush_if,
  output logic [31:0] br_cnt,
  output logic [31:0] mp_cnt
);

  localparam int unsigned TAG_W   = 30 - IDX_W;
  localparam int unsigned ENTRIES = 1 << IDX_W;

  logic [ENTRIES-1:0] valid_q;
  logic [1:0]         ctr_q    [ENTRIES];
  logic [TAG_W-1:0]   tag_q    [ENTRIES];
  logic [31:0]        target_q [ENTRIES];

  logic [31:0]      pc_q, pc_d;
  logic [31:0]      br_cnt_q, mp_cnt_q;
  logic [IDX_W-1:0] look_idx, upd_idx;
  logic [TAG_W-1:0] look_tag, upd_tag;
  logic             look_hit, upd_hit;
  logic             predict;
  logic [31:0]      pred_next;
  logic [1:0]       ctr_upd;

  // Lookup reads the registered table, so a same-cycle update is seen next cycle.
  always_comb begin
    look_idx  = pc_q[IDX_W+1:2];
    look_tag  = pc_q[31:IDX_W+2];
    look_hit  = valid_q[look_idx] && (tag_q[look_idx] == look_tag);
    predict   = look_hit && ctr_q[look_idx][1];
    pred_next = predict ? target_q[look_idx] : pc_q + 32'd4;
  end

  always_comb begin
    pc_d = pred_next;
    if (redirect_valid) begin
      pc_d = redirect_pc;
    end else if (stall) begin
      pc_d = pc_q;
    end
  end

  always_comb begin
    upd_idx = upd_pc[IDX_W+1:2];
    upd_tag = upd_pc[31:IDX_W+2];
    upd_hit = valid_q[upd_idx] && (tag_q[upd_idx] == upd_tag);
    ctr_upd = ctr_q[upd_idx];
    if (upd_taken) begin
      if (ctr_q[upd_idx] != 2'b11) ctr_upd = ctr_q[upd_idx] + 2'b01;
    end else begin
      if (ctr_q[upd_idx] != 2'b00) ctr_upd = ctr_q[upd_idx] - 2'b01;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q <= RESET_PC;
    end else begin
      pc_q <= pc_d;
    end
  end

  // A taken miss allocates, evicting whatever entry aliases to the same index.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
      for (int i = 0; i < int'(ENTRIES); i++) begin
        ctr_q[i]    <= 2'b01;
        tag_q[i]    <= '0;
        target_q[i] <= '0;
      end
    end else if (upd_valid) begin
      if (upd_hit) begin
        ctr_q[upd_idx] <= ctr_upd;
        if (upd_taken) target_q[upd_idx] <= upd_target;
      end else if (upd_taken) begin
        valid_q[upd_idx]  <= 1'b1;
        tag_q[upd_idx]    <= upd_tag;
        target_q[upd_idx] <= upd_target;
        ctr_q[upd_idx]    <= 2'b10;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      br_cnt_q <= '0;
      mp_cnt_q <= '0;
    end else begin
      if (upd_valid)      br_cnt_q <= br_cnt_q + 32'd1;
      if (redirect_valid) mp_cnt_q <= mp_cnt_q + 32'd1;
    end
  end

  assign pc_if      = pc_q;
  assign predict_if = predict;
  assign flush_if   = redirect_valid;
  assign br_cnt     = br_cnt_q;
  assign mp_cnt     = mp_cnt_q;

endmodule
